// File: rtl/interp_linear.sv
`default_nettype none
// ============================================================================
//  Module   : interp_linear
//  Purpose  : Linear-interpolating upsampler. Captures one unsigned sample
//             every RATIO fast clocks and ramps the registered output along a
//             straight line from the previous sample to the current one,
//             using an exact quotient/remainder accumulator (no drift).
//  Revision : 1.0  initial release
// ============================================================================
module interp_linear #(
  parameter int WIDTH = 20,
  parameter int RATIO = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] v_in,
  output logic [WIDTH-1:0] interp_o
);

  localparam int KW = $clog2(RATIO);
  localparam int RW = KW + 1;

  localparam logic        [KW-1:0] c_K_LAST  = KW'(RATIO - 1);
  localparam logic        [RW-1:0] c_RATIO_R = RW'(RATIO);
  localparam logic signed [WIDTH:0] c_RATIO_S = (WIDTH+1)'(RATIO);

  logic        [KW-1:0]    r_k;
  logic        [WIDTH-1:0] r_x_prev;
  logic        [WIDTH-1:0] r_x_cur;
  logic signed [WIDTH:0]   r_dq;
  logic        [KW-1:0]    r_dr;
  logic signed [WIDTH:0]   r_q;
  logic        [KW-1:0]    r_r;
  logic        [WIDTH-1:0] r_out;

  logic signed [WIDTH:0]   w_delta;
  logic signed [WIDTH:0]   w_quot;
  logic signed [WIDTH:0]   w_rem;
  logic signed [WIDTH:0]   w_dq;
  logic        [KW-1:0]    w_dr;
  logic        [RW-1:0]    w_r_sum;
  logic                    w_wrap;
  logic        [KW-1:0]    w_r_next;
  logic signed [WIDTH:0]   w_q_next;
  logic signed [WIDTH+1:0] w_out_sum;

  // Floor-divide the new segment delta by RATIO and step the accumulator.
  always_comb begin
    w_delta   = $signed({1'b0, v_in}) - $signed({1'b0, r_x_cur});
    w_quot    = w_delta / c_RATIO_S;
    w_rem     = w_delta % c_RATIO_S;
    w_dq      = w_quot;
    w_dr      = KW'(w_rem);
    // Truncating division rounds toward zero; pull negative cases down by one.
    if (w_rem < 0) begin
      w_dq = w_quot - 1;
      w_dr = KW'(w_rem + c_RATIO_S);
    end
    w_r_sum   = {1'b0, r_r} + {1'b0, r_dr};
    w_wrap    = (w_r_sum >= c_RATIO_R);
    w_r_next  = w_wrap ? KW'(w_r_sum - c_RATIO_R) : KW'(w_r_sum);
    w_q_next  = r_q + r_dq + $signed({{WIDTH{1'b0}}, w_wrap});
    w_out_sum = $signed({2'b00, r_x_prev}) + $signed({w_q_next[WIDTH], w_q_next});
  end

  // Phase counter, sample capture, accumulator and registered output.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_k      <= '0;
      r_x_prev <= '0;
      r_x_cur  <= '0;
      r_dq     <= '0;
      r_dr     <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_out    <= '0;
    end else begin
      r_k <= (r_k == c_K_LAST) ? '0 : r_k + 1'b1;
      if (r_k == '0) begin
        // New segment: output starts exactly at the outgoing sample.
        r_x_prev <= r_x_cur;
        r_x_cur  <= v_in;
        r_dq     <= w_dq;
        r_dr     <= w_dr;
        r_q      <= '0;
        r_r      <= '0;
        r_out    <= r_x_cur;
      end else begin
        r_q      <= w_q_next;
        r_r      <= w_r_next;
        r_out    <= WIDTH'(w_out_sum);
      end
    end
  end

  assign interp_o = r_out;

endmodule
`default_nettype wire

// File: tb/tb_interp_linear.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interp_linear
//  Purpose  : Self-checking bench for interp_linear: closed-form reference
//             model compared every clock, plus hand-computed pinned values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interp_linear;

  localparam int WIDTH = 20;
  localparam int RATIO = 50;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] v_in;
  logic [WIDTH-1:0] interp_o;

  int checks   = 0;
  int failures = 0;

  interp_linear #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clock    (clock),
    .reset    (reset),
    .v_in     (v_in),
    .interp_o (interp_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Exact floor division (toward negative infinity).
  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model state: segment samples and edge count since release.
  longint m_prev = 0;
  longint m_cur  = 0;
  longint m_c    = 0;
  bit     m_on   = 1'b0;

  // Compare process: evaluate the model for each edge, check 1 time unit later.
  always @(posedge clock) begin
    logic             rs;
    logic [WIDTH-1:0] vs;
    longint           k;
    longint           expv;
    rs = reset;
    vs = v_in;
    #1;
    if (!rs) begin
      m_on   = 1'b1;
      m_prev = 0;
      m_cur  = 0;
      m_c    = 0;
      expv   = 0;
    end else begin
      k = m_c % RATIO;
      if (k == 0) begin
        m_prev = m_cur;
        m_cur  = longint'(vs);
      end
      expv = m_prev + floor_div((m_cur - m_prev) * k, RATIO);
      m_c  = m_c + 1;
    end
    if (m_on) begin
      checks++;
      if (longint'(interp_o) != expv) begin
        failures++;
        $display("FAIL model edge=%0d: interp_o=%0d expected=%0d", m_c, interp_o, expv);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pin(input string nm, input int expv);
    checks++;
    if (int'(interp_o) != expv) begin
      failures++;
      $display("FAIL %s: interp_o=%0d expected=%0d", nm, interp_o, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    v_in  = 20'd12345;
    tick(5);
    pin("reset_hold", 0);

    // Constant 1000 from release.
    reset = 1'b1;
    v_in  = 20'd1000;
    tick(1);  pin("const_k0", 0);
    tick(1);  pin("const_k1", 20);
    tick(48); pin("const_k49", 980);
    tick(1);  pin("const_seg1_k0", 1000);
    tick(49); pin("const_seg1_k49", 1000);

    // Rising ramp 0 -> 5000.
    do_reset();
    v_in = 20'd0;
    tick(50);
    v_in = 20'd5000;
    tick(1);  pin("rise_k0", 0);
    tick(1);  pin("rise_k1", 100);
    tick(48); pin("rise_k49", 4900);
    tick(1);  pin("rise_next_k0", 5000);

    // Falling 5000 -> 0.
    tick(49);
    v_in = 20'd0;
    tick(1);  pin("fall_k0", 5000);
    tick(1);  pin("fall_k1", 4900);
    tick(24); pin("fall_k25", 2500);
    tick(24); pin("fall_k49", 100);

    // Rounding 0 -> 100 -> 99.
    v_in = 20'd100;
    tick(1);  pin("rnd_up_k0", 0);
    tick(49); pin("rnd_up_k49", 98);
    v_in = 20'd99;
    tick(1);  pin("rnd_dn_k0", 100);
    tick(1);  pin("rnd_dn_k1", 99);
    tick(48); pin("rnd_dn_k49", 99);

    // Mixed segments, including odd negative deltas.
    v_in = 20'd777;     tick(50);
    v_in = 20'd777;     tick(50);
    v_in = 20'd1048575; tick(50);
    v_in = 20'd3;       tick(50);
    v_in = 20'd123457;  tick(50);

    // Full scale 0 -> 1048575.
    do_reset();
    v_in = 20'd0;
    tick(50);
    v_in = 20'd1048575;
    tick(1);  pin("full_k0", 0);
    tick(49); pin("full_k49", 1027603);
    tick(1);  pin("full_next_k0", 1048575);

    // Reset mid-segment.
    do_reset();
    v_in = 20'd0;
    tick(50);
    v_in = 20'd5000;
    tick(1);
    tick(25); pin("mid_k25", 2500);
    reset = 1'b0;
    tick(1);  pin("mid_reset", 0);
    tick(2);
    reset = 1'b1;
    v_in  = 20'd1000;
    tick(1);  pin("mid_restart_k0", 0);
    tick(1);  pin("mid_restart_k1", 20);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
